// File: rtl/sound_pwm_driver.sv
// -----------------------------------------------------------------------------
// sound_pwm_driver
//   Sink end of the sound path. Takes N-bit unsigned samples over a valid/ready
//   handshake and renders them as a 1-bit PWM audio pin with a period of
//   2^N ticks, one tick every PRESCALE clocks.
//
//   Double buffered: r_duty drives the current period, r_pend holds the next
//   sample. The swap happens only at a period boundary, so pwm_o never changes
//   duty mid-period.
//
// Parameters
//   N         sample width; PWM period = 2^N ticks
//   PRESCALE  clk cycles per PWM tick (>= 1)
//
// Ports
//   clk             system clock
//   nRst            asynchronous active-low reset
//   enable_i        run request (level)
//   sample_i        unsigned sample / duty value
//   sample_valid_i  sample_i is valid
//   sample_ready_o  pending register empty; transfer on valid && ready
//   pwm_o           registered PWM output
//   period_start_o  1-cycle pulse when duty is (re)loaded
//   underrun_o      1-cycle pulse when a boundary finds no pending sample
//
// Build option
//   UNDERRUN_MIDSCALE_EN  when defined, an underrun loads duty with 2^(N-1)
//                         (DC midpoint, i.e. silence); when undefined the
//                         duty of the previous period is repeated.
// -----------------------------------------------------------------------------
module sound_pwm_driver #(
  parameter int N        = 8,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         enable_i,
  input  logic [N-1:0] sample_i,
  input  logic         sample_valid_i,
  output logic         sample_ready_o,
  output logic         pwm_o,
  output logic         period_start_o,
  output logic         underrun_o
);

  // A PRESCALE of 1 still gets a 1-bit counter so the vector is never empty.
  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

`ifdef UNDERRUN_MIDSCALE_EN
  localparam logic [N-1:0]  MIDSCALE   = {1'b1, {(N-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // counters parked, output low
    PRIME = 2'd1,  // waiting for the first sample before starting a period
    RUN   = 2'd2,  // playing, reloading at every boundary
    STOP  = 2'd3   // finishing the current period, then back to IDLE
  } state_t;

  state_t         r_state;
  logic [PW-1:0]  r_presc;
  logic [N-1:0]   r_cnt;
  logic [N-1:0]   r_duty;
  logic [N-1:0]   r_pend;
  logic           r_pend_full;
  logic           r_pwm;
  logic           r_period_start;
  logic           r_underrun;

  logic           w_running;
  logic           w_tick;
  logic           w_boundary;
  logic           w_accept;

  assign w_running  = (r_state == RUN) || (r_state == STOP);
  assign w_tick     = w_running && (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_cnt == '1);

  // Ready comes straight from a flop, so there is no combinational path
  // from sample_valid_i to sample_ready_o.
  assign w_accept       = sample_valid_i && !r_pend_full;
  assign sample_ready_o = !r_pend_full;

  assign pwm_o          = r_pwm;
  assign period_start_o = r_period_start;
  assign underrun_o     = r_underrun;

  // NOTE: all state here is sequential and written with non-blocking (<=)
  // assignments, so every right-hand side sees the values from before the
  // edge; a later assignment to the same register in this block wins.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state        <= IDLE;
      r_presc        <= '0;
      r_cnt          <= '0;
      r_duty         <= '0;
      // NOTE: the sample holding registers are reset as well; it is only a
      // few flops, and an abort must discard any in-flight sample.
      r_pend         <= '0;
      r_pend_full    <= 1'b0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_period_start <= 1'b0;
      r_underrun     <= 1'b0;

      // Registered compare: pwm_o shows the level of the tick held during
      // the previous clock, which keeps the output free of decode glitches.
      r_pwm <= w_running && (r_cnt < r_duty);

      // Tick and PWM counters only move while a period is being played.
      if (w_running) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_presc <= '0;
        r_cnt   <= '0;
      end

      // Upstream transfer. It can never collide with a reload below:
      // transfers need the pending slot empty, reloads need it full.
      if (w_accept) begin
        r_pend      <= sample_i;
        r_pend_full <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (enable_i) begin
            r_state <= PRIME;
          end
        end

        PRIME: begin
          if (!enable_i) begin
            r_state <= IDLE;
          end else if (r_pend_full) begin
            r_duty         <= r_pend;
            r_pend_full    <= 1'b0;
            r_period_start <= 1'b1;
            r_state        <= RUN;
          end
        end

        RUN: begin
          if (w_boundary) begin
            r_period_start <= 1'b1;
            if (r_pend_full) begin
              r_duty      <= r_pend;
              r_pend_full <= 1'b0;
            end else begin
              r_underrun <= 1'b1;
`ifdef UNDERRUN_MIDSCALE_EN
              r_duty     <= MIDSCALE;
`endif
            end
          end
          if (!enable_i) begin
            r_state <= STOP;
          end
        end

        STOP: begin
          // The period that is running always completes; the pending
          // sample is kept for the next start.
          if (w_boundary) begin
            r_state <= IDLE;
          end else if (enable_i) begin
            r_state <= RUN;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_sound_pwm_driver
//   Self-checking bench for sound_pwm_driver (N=8, PRESCALE=2, so the tick
//   gating between clocks is exercised). A behavioural reference model tracks
//   the position inside the PWM period in clocks and keeps the pending sample
//   in a queue; every clock the four outputs are compared against it. Directed
//   scenarios also check per-period high-time counts against fixed values.
// -----------------------------------------------------------------------------
module tb_sound_pwm_driver;

  localparam int N        = 8;
  localparam int PRESCALE = 2;
  localparam int PERIOD   = (1 << N) * PRESCALE;  // clocks per PWM period

  logic         clk = 1'b0;
  logic         nRst;
  logic         enable_i;
  logic [N-1:0] sample_i;
  logic         sample_valid_i;
  logic         sample_ready_o;
  logic         pwm_o;
  logic         period_start_o;
  logic         underrun_o;

  always #5 clk = ~clk;

  sound_pwm_driver #(.N(N), .PRESCALE(PRESCALE)) dut (
    .clk            (clk),
    .nRst           (nRst),
    .enable_i       (enable_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .underrun_o     (underrun_o)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ------------------------------------------------------- reference model
  typedef enum int {S_OFF, S_WAIT, S_PLAY, S_DRAIN} mode_e;

  mode_e m_mode;
  int    m_phase;    // clocks elapsed in the current PWM period
  int    m_duty;
  int    m_pend[$];  // at most one waiting sample
  bit    exp_pwm, exp_ps, exp_ur;

  task automatic model_reset();
    m_mode  = S_OFF;
    m_phase = 0;
    m_duty  = 0;
    m_pend.delete();
    exp_pwm = 1'b0;
    exp_ps  = 1'b0;
    exp_ur  = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit vld, input int smp);
    bit playing, last, take;
    playing = (m_mode == S_PLAY) || (m_mode == S_DRAIN);
    last    = playing && (m_phase == PERIOD - 1);
    take    = vld && (m_pend.size() == 0);
    exp_pwm = playing && ((m_phase / PRESCALE) < m_duty);
    exp_ps  = 1'b0;
    exp_ur  = 1'b0;
    case (m_mode)
      S_OFF:  if (en) m_mode = S_WAIT;
      S_WAIT: begin
        if (!en) m_mode = S_OFF;
        else if (m_pend.size() > 0) begin
          m_duty = m_pend.pop_front();
          exp_ps = 1'b1;
          m_mode = S_PLAY;
        end
      end
      S_PLAY: begin
        if (last) begin
          exp_ps = 1'b1;
          if (m_pend.size() > 0) m_duty = m_pend.pop_front();
          else begin
            exp_ur = 1'b1;
`ifdef UNDERRUN_MIDSCALE_EN
            m_duty = 1 << (N - 1);
`endif
          end
        end
        if (!en) m_mode = S_DRAIN;
      end
      S_DRAIN: begin
        if (last) m_mode = S_OFF;
        else if (en) m_mode = S_PLAY;
      end
      default: m_mode = S_OFF;
    endcase
    m_phase = playing ? (last ? 0 : m_phase + 1) : 0;
    if (take) m_pend.push_back(smp);
  endtask

  // --------------------------------------------------- stimulus / monitors
  int unsigned src[$];   // upstream samples waiting to be offered
  bit          gate;     // allows a new valid to be raised this cycle
  bit          en_req;
  int          cyc;
  int          cur_hi;   // pwm_o high clocks since the last period_start_o
  bit          seen_ps;
  int          hist[$];  // high count of each completed period
  int          ps_cyc[$];
  bit          ps_ur[$];

  task automatic clear_hist();
    hist.delete();
    ps_cyc.delete();
    ps_ur.delete();
    seen_ps = 1'b0;
    cur_hi  = 0;
  endtask

  // One clock: drive on the falling edge, step the model on the rising edge,
  // compare just after it.
  task automatic cycle();
    bit rdy;
    @(negedge clk);
    if (src.size() > 0 && (sample_valid_i || gate)) begin
      sample_valid_i = 1'b1;
      sample_i       = N'(src[0]);
    end else begin
      sample_valid_i = 1'b0;
      sample_i       = N'($urandom);
    end
    enable_i = en_req;
    rdy      = sample_ready_o;
    @(posedge clk);
    model_step(enable_i, sample_valid_i, int'(sample_i));
    if (sample_valid_i && rdy) void'(src.pop_front());
    #1;
    check("cycle", {pwm_o, sample_ready_o, period_start_o, underrun_o},
          {exp_pwm, (m_pend.size() == 0), exp_ps, exp_ur});
    cyc++;
    cur_hi += int'(pwm_o);
    if (period_start_o) begin
      if (seen_ps) hist.push_back(cur_hi);
      seen_ps = 1'b1;
      cur_hi  = 0;
      ps_cyc.push_back(cyc);
      ps_ur.push_back(underrun_o);
    end
  endtask

  task automatic run_until_ps(input int count, input int budget);
    int n = 0;
    while (ps_cyc.size() < count && n < budget) begin
      cycle();
      n++;
    end
    check("ps_wait", (ps_cyc.size() >= count), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm"},   pwm_o,          0);
    check({tag, "_ready"}, sample_ready_o, 1);
    check({tag, "_ps"},    period_start_o, 0);
    check({tag, "_ur"},    underrun_o,     0);
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    nRst           = 1'b0;
    enable_i       = 1'b0;
    sample_valid_i = 1'b0;
    sample_i       = '0;
    en_req         = 1'b0;
    gate           = 1'b1;
    cyc            = 0;
    model_reset();
    clear_hist();

    // Reset and idle
    repeat (3) @(posedge clk);
    #2 nRst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (5) cycle();

    // A sample offered in IDLE is taken but does not start anything
    src.push_back(32'h40);
    repeat (6) cycle();
    check("idle_ready", sample_ready_o, 0);
    check("idle_pwm",   pwm_o,          0);
    check("idle_no_ps", ps_cyc.size(),  0);

    // Start with 0x40 pending, then stream 00, FF, 80, C0 and starve
    clear_hist();
    src.push_back(32'h00);
    src.push_back(32'hFF);
    src.push_back(32'h80);
    src.push_back(32'hC0);
    en_req = 1'b1;
    run_until_ps(1, 8);
    check("prime_ready", sample_ready_o, 1);
    run_until_ps(7, 8 * PERIOD);
    check("high_40", hist[0], 64 * PRESCALE);
    check("high_00", hist[1], 0);
    check("high_ff", hist[2], 255 * PRESCALE);
    check("high_80", hist[3], 128 * PRESCALE);
    check("high_c0", hist[4], 192 * PRESCALE);
`ifdef UNDERRUN_MIDSCALE_EN
    check("high_underrun", hist[5], 128 * PRESCALE);
`else
    check("high_underrun", hist[5], 192 * PRESCALE);
`endif
    for (int i = 1; i < 7; i++) check("ps_gap", ps_cyc[i] - ps_cyc[i-1], PERIOD);
    for (int i = 0; i < 7; i++) check("ur_at_ps", ps_ur[i], (i >= 5));

    // Drop enable at pwmCount=10: the period completes, then IDLE, pending kept
    src.push_back(32'h20);
    src.push_back(32'h30);
    clear_hist();
    run_until_ps(1, 2 * PERIOD);
    repeat (10 * PRESCALE) cycle();
    en_req = 1'b0;
    repeat (PERIOD + 64) cycle();
    check("stop_high",  cur_hi,         32 * PRESCALE);
    check("stop_no_ps", ps_cyc.size(),  1);
    check("stop_pwm",   pwm_o,          0);
    check("stop_ready", sample_ready_o, 0);

    // Re-enable: the retained 0x30 starts the next period
    clear_hist();
    en_req = 1'b1;
    run_until_ps(2, PERIOD + 16);
    check("resume_high",  hist[0],        48 * PRESCALE);
    check("resume_ready", sample_ready_o, 1);

    // Reset mid-period while pwm_o is high
    repeat (4) cycle();
    check("pre_rst_pwm", pwm_o, 1);
    #1 nRst = 1'b0;
    model_reset();
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #2 nRst = 1'b1;
    clear_hist();
    repeat (40) cycle();
    check("no_restart", ps_cyc.size(), 0);
    src.push_back(32'h10);
    run_until_ps(1, 16);

    // Randomised run: enable toggling, random samples and valid gaps
    for (int seg = 0; seg < 24; seg++) begin
      int len;
      en_req = ($urandom_range(0, 4) != 0);
      len    = $urandom_range(20, 1200);
      for (int k = 0; k < len; k++) begin
        if (src.size() == 0 && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 5))
            0:       src.push_back(32'h00);
            1:       src.push_back(32'hFF);
            default: src.push_back($urandom_range(0, 255));
          endcase
        end
        gate = ($urandom_range(0, 1) == 1);
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
